// File: rtl/hd63701_intc_pkg.sv
// Shared constants for the HD63701 interrupt controller: FSM states,
// source indices into the eligible vector, and the vector offsets.
// Optional feature macro: HD63701_INTC_CMI_EN (adds timer-2 compare-match).
package hd63701_intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } intc_state_e;

    // Bit positions in the eligible vector (priority is set by the encoder)
    localparam int SRC_NMI  = 0;
    localparam int SRC_IRQ1 = 1;
    localparam int SRC_ICI  = 2;
    localparam int SRC_OCI  = 3;
    localparam int SRC_TOI  = 4;
    localparam int SRC_SCI  = 5;
`ifdef HD63701_INTC_CMI_EN
    localparam int SRC_CMI  = 6;
    localparam int NUM_SRC  = 7;
`else
    localparam int NUM_SRC  = 6;
`endif

    // Offsets from $FFE0
    localparam logic [4:0] VEC_NONE = 5'h00;
    localparam logic [4:0] VEC_NMI  = 5'h1C;
    localparam logic [4:0] VEC_IRQ1 = 5'h18;
    localparam logic [4:0] VEC_ICI  = 5'h16;
    localparam logic [4:0] VEC_OCI  = 5'h14;
    localparam logic [4:0] VEC_TOI  = 5'h12;
    localparam logic [4:0] VEC_SCI  = 5'h10;
`ifdef HD63701_INTC_CMI_EN
    localparam logic [4:0] VEC_CMI  = 5'h0C;
`endif

    localparam int HOLD_W = 4;

endpackage

// File: rtl/hd63701_intc_prio.sv
// Fixed-priority encoder: picks the highest-priority eligible source and
// returns its vector offset. Purely combinational.
// Optional feature macro: HD63701_INTC_CMI_EN (CMI slots between TOI and SCI).
module hd63701_intc_prio
    import hd63701_intc_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    output logic               win_valid,
    output logic [4:0]         win_vec
);

    // Priority chain, highest first; no winner leaves the vector at zero
    always_comb begin
        win_valid = 1'b1;
        win_vec   = VEC_NONE;
        if (eligible[SRC_NMI])       win_vec = VEC_NMI;
        else if (eligible[SRC_IRQ1]) win_vec = VEC_IRQ1;
        else if (eligible[SRC_ICI])  win_vec = VEC_ICI;
        else if (eligible[SRC_OCI])  win_vec = VEC_OCI;
        else if (eligible[SRC_TOI])  win_vec = VEC_TOI;
`ifdef HD63701_INTC_CMI_EN
        else if (eligible[SRC_CMI])  win_vec = VEC_CMI;
`endif
        else if (eligible[SRC_SCI])  win_vec = VEC_SCI;
        else                         win_valid = 1'b0;
    end

endmodule

// File: rtl/hd63701_intc.sv
// HD63701 interrupt controller: latches NMI edges, masks the level sources
// with the CCR I flag, raises a prioritised request to the core and enforces
// a short quiet period after each acknowledge.
// Optional feature macro: HD63701_INTC_CMI_EN (adds cmi_in, vector 5'h0C).
module hd63701_intc
    import hd63701_intc_pkg::*;
#(
    parameter int HOLD_CYC = 2
)
(
    input  logic       mcu_clx2,
    input  logic       mcu_rst,
    input  logic       nmi_in,
    input  logic       irq1_in,
    input  logic       ici_in,
    input  logic       oci_in,
    input  logic       toi_in,
    input  logic       sci_in,
`ifdef HD63701_INTC_CMI_EN
    input  logic       cmi_in,
`endif
    input  logic       i_mask,
    input  logic       int_ack,
    output logic       int_req,
    output logic [4:0] int_vec,
    output logic       nmi_pend
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    intc_state_e        state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [4:0]         int_vec_q, int_vec_d;
    logic               nmi_lat_q, nmi_lat_d;
    logic               nmi_prev_q, nmi_prev_d;
    logic               nmi_arm_q, nmi_arm_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic               nmi_edge;
    logic               nmi_clr;
    logic [NUM_SRC-1:0] eligible;
    logic               win_valid;
    logic [4:0]         win_vec;

    // Edge detect (armed only once nmi_in has been seen low) and source masking
    always_comb begin
        nmi_edge   = nmi_in & ~nmi_prev_q & nmi_arm_q;
        nmi_prev_d = nmi_in;
        nmi_arm_d  = nmi_arm_q | ~nmi_in;
        eligible             = '0;
        eligible[SRC_NMI]    = nmi_lat_q | nmi_edge;
        eligible[SRC_IRQ1]   = irq1_in & ~i_mask;
        eligible[SRC_ICI]    = ici_in  & ~i_mask;
        eligible[SRC_OCI]    = oci_in  & ~i_mask;
        eligible[SRC_TOI]    = toi_in  & ~i_mask;
        eligible[SRC_SCI]    = sci_in  & ~i_mask;
`ifdef HD63701_INTC_CMI_EN
        eligible[SRC_CMI]    = cmi_in  & ~i_mask;
`endif
    end

    hd63701_intc_prio u_prio (
        .eligible  (eligible),
        .win_valid (win_valid),
        .win_vec   (win_vec)
    );

    // Request FSM; a HOLD that expires with a winner goes straight to PEND so
    // the quiet gap after an ack is exactly HOLD_CYC cycles
    always_comb begin
        state_d    = state_q;
        int_req_d  = int_req_q;
        int_vec_d  = int_vec_q;
        hold_cnt_d = hold_cnt_q;
        nmi_clr    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d   = ST_PEND;
                    int_req_d = 1'b1;
                    int_vec_d = win_vec;
                end
            end
            ST_PEND: begin
                if (int_ack) begin
                    state_d    = ST_HOLD;
                    int_req_d  = 1'b0;
                    hold_cnt_d = HOLD_LOAD;
                    nmi_clr    = (int_vec_q == VEC_NMI);
                end else if (win_valid) begin
                    int_vec_d = win_vec;
                end else begin
                    state_d   = ST_IDLE;
                    int_req_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end else if (win_valid) begin
                    state_d   = ST_PEND;
                    int_req_d = 1'b1;
                    int_vec_d = win_vec;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                int_req_d = 1'b0;
            end
        endcase
        nmi_lat_d = nmi_edge | (nmi_lat_q & ~nmi_clr);
    end

    // State registers; reset discards any request in flight
    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            state_q    <= ST_IDLE;
            int_req_q  <= 1'b0;
            int_vec_q  <= VEC_NONE;
            nmi_lat_q  <= 1'b0;
            nmi_prev_q <= 1'b0;
            nmi_arm_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            int_req_q  <= int_req_d;
            int_vec_q  <= int_vec_d;
            nmi_lat_q  <= nmi_lat_d;
            nmi_prev_q <= nmi_prev_d;
            nmi_arm_q  <= nmi_arm_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign int_req  = int_req_q;
    assign int_vec  = int_vec_q;
    assign nmi_pend = nmi_lat_q;

endmodule

// File: tb/tb_hd63701_intc.sv
// Scoreboard bench for hd63701_intc: each stimulus cycle queues the outputs
// expected after the next rising edge; a monitor pops and compares them.
// Optional feature macro: HD63701_INTC_CMI_EN (enables the CMI vectors).
module tb_hd63701_intc;

    localparam logic [5:0] S_NONE = 6'b000000;
    localparam logic [5:0] S_IRQ1 = 6'b100000;
    localparam logic [5:0] S_ICI  = 6'b010000;
    localparam logic [5:0] S_OCI  = 6'b001000;
    localparam logic [5:0] S_TOI  = 6'b000100;
    localparam logic [5:0] S_SCI  = 6'b000010;
    localparam logic [5:0] S_CMI  = 6'b000001;

    typedef struct {
        logic       req;
        logic [4:0] vec;
        logic       pend;
        string      name;
    } exp_t;

    logic       mcu_clx2 = 1'b0;
    logic       mcu_rst  = 1'b1;
    logic       nmi_in   = 1'b0;
    logic       irq1_in  = 1'b0;
    logic       ici_in   = 1'b0;
    logic       oci_in   = 1'b0;
    logic       toi_in   = 1'b0;
    logic       sci_in   = 1'b0;
    logic       cmi_in   = 1'b0;
    logic       i_mask   = 1'b0;
    logic       int_ack  = 1'b0;
    logic       int_req;
    logic [4:0] int_vec;
    logic       nmi_pend;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    hd63701_intc #(.HOLD_CYC(2)) dut (
        .mcu_clx2 (mcu_clx2),
        .mcu_rst  (mcu_rst),
        .nmi_in   (nmi_in),
        .irq1_in  (irq1_in),
        .ici_in   (ici_in),
        .oci_in   (oci_in),
        .toi_in   (toi_in),
        .sci_in   (sci_in),
`ifdef HD63701_INTC_CMI_EN
        .cmi_in   (cmi_in),
`endif
        .i_mask   (i_mask),
        .int_ack  (int_ack),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .nmi_pend (nmi_pend)
    );

    always #5 mcu_clx2 = ~mcu_clx2;

    // Drive one cycle of inputs at the falling edge and queue what the DUT
    // must show after the following rising edge
    task automatic applyStimulus(input logic r, input logic n, input logic [5:0] src,
                                 input logic m, input logic a, input logic er,
                                 input logic [4:0] ev, input logic ep, input string nm);
        exp_t e;
        @(negedge mcu_clx2);
        mcu_rst = r;
        nmi_in  = n;
        {irq1_in, ici_in, oci_in, toi_in, sci_in, cmi_in} = src;
        i_mask  = m;
        int_ack = a;
        e.req  = er;
        e.vec  = ev;
        e.pend = ep;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (int_req !== e.req || int_vec !== e.vec || nmi_pend !== e.pend) begin
            mismatched++;
            $display("[TB] FAIL %s: got req=%b vec=%h pend=%b, want req=%b vec=%h pend=%b",
                     e.name, int_req, int_vec, nmi_pend, e.req, e.vec, e.pend);
        end
    endtask

    // Monitor: compare the oldest expectation shortly after each rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge mcu_clx2);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        // reset
        applyStimulus(1, 0, S_NONE, 0, 0, 0, 5'h00, 0, "rst0");
        applyStimulus(1, 0, S_NONE, 0, 0, 0, 5'h00, 0, "rst1");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h00, 0, "idle");
        // TOI request, ack, 2-cycle quiet gap, re-raise
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "toi_req");
        applyStimulus(0, 0, S_TOI,  0, 1, 0, 5'h12, 0, "toi_ack");
        applyStimulus(0, 0, S_TOI,  0, 0, 0, 5'h12, 0, "toi_hold1");
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "toi_rereq");
        applyStimulus(0, 0, S_TOI,  0, 1, 0, 5'h12, 0, "toi_ack2");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h12, 0, "toi_hold2a");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h12, 0, "toi_idle");
        // SCI pre-empted by IRQ1 before ack
        applyStimulus(0, 0, S_SCI,          0, 0, 1, 5'h10, 0, "sci_req");
        applyStimulus(0, 0, S_SCI | S_IRQ1, 0, 0, 1, 5'h18, 0, "irq1_preempt");
        applyStimulus(0, 0, S_SCI | S_IRQ1, 0, 1, 0, 5'h18, 0, "irq1_ack");
        applyStimulus(0, 0, S_NONE,         0, 0, 0, 5'h18, 0, "irq1_hold");
        applyStimulus(0, 0, S_NONE,         0, 0, 0, 5'h18, 0, "irq1_idle");
        // OCI withdrawn by mask, then NMI through the mask
        applyStimulus(0, 0, S_OCI, 0, 0, 1, 5'h14, 0, "oci_req");
        applyStimulus(0, 0, S_OCI, 1, 0, 0, 5'h14, 0, "oci_masked");
        applyStimulus(0, 1, S_OCI, 1, 0, 1, 5'h1C, 1, "nmi_masked_req");
        applyStimulus(0, 1, S_OCI, 1, 0, 1, 5'h1C, 1, "nmi_level_held");
        applyStimulus(0, 1, S_OCI, 1, 1, 0, 5'h1C, 0, "nmi_ack");
        applyStimulus(0, 0, S_OCI, 1, 0, 0, 5'h1C, 0, "nmi_hold");
        applyStimulus(0, 0, S_OCI, 1, 0, 0, 5'h1C, 0, "nmi_idle_masked");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "idle2");
        // maskable priority ordering
        applyStimulus(0, 0, S_OCI | S_TOI | S_SCI,                  0, 0, 1, 5'h14, 0, "prio_oci");
        applyStimulus(0, 0, S_ICI | S_OCI | S_TOI | S_SCI,          0, 0, 1, 5'h16, 0, "prio_ici");
        applyStimulus(0, 0, S_IRQ1 | S_ICI | S_OCI | S_TOI | S_SCI, 0, 0, 1, 5'h18, 0, "prio_irq1");
        applyStimulus(0, 0, S_OCI | S_TOI | S_SCI,                  0, 0, 1, 5'h14, 0, "prio_drop");
        applyStimulus(0, 0, S_NONE,                                 0, 0, 0, 5'h14, 0, "prio_idle");
        // NMI edge coincident with ICI ack
        applyStimulus(0, 0, S_ICI,  0, 0, 1, 5'h16, 0, "ici_req");
        applyStimulus(0, 1, S_ICI,  0, 1, 0, 5'h16, 1, "ici_ack_nmi");
        applyStimulus(0, 1, S_NONE, 0, 0, 0, 5'h16, 1, "ici_hold");
        applyStimulus(0, 1, S_NONE, 0, 0, 1, 5'h1C, 1, "nmi_after_hold");
        applyStimulus(0, 1, S_NONE, 0, 1, 0, 5'h1C, 0, "nmi_ack2");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "nmi_hold2");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "idle3");
        // new NMI edge on the NMI ack cycle stays pending
        applyStimulus(0, 1, S_NONE, 0, 0, 1, 5'h1C, 1, "nmi3_req");
        applyStimulus(0, 0, S_NONE, 0, 0, 1, 5'h1C, 1, "nmi3_low");
        applyStimulus(0, 1, S_NONE, 0, 1, 0, 5'h1C, 1, "nmi3_ack_edge");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 1, "nmi3_hold");
        applyStimulus(0, 0, S_NONE, 0, 0, 1, 5'h1C, 1, "nmi4_req");
        applyStimulus(0, 0, S_NONE, 0, 1, 0, 5'h1C, 0, "nmi4_ack");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "nmi4_hold");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "idle4");
        // ack outside PEND is ignored
        applyStimulus(0, 0, S_NONE, 0, 1, 0, 5'h1C, 0, "ack_in_idle");
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "toi5_req");
        applyStimulus(0, 0, S_TOI,  0, 1, 0, 5'h12, 0, "toi5_ack");
        applyStimulus(0, 0, S_TOI,  0, 1, 0, 5'h12, 0, "ack_in_hold");
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "toi5_rereq");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h12, 0, "toi5_withdrawn");
        // reset mid-PEND and mid-HOLD
        applyStimulus(0, 0, S_IRQ1, 0, 0, 1, 5'h18, 0, "irq1_req2");
        applyStimulus(1, 0, S_IRQ1, 0, 0, 0, 5'h00, 0, "rst_in_pend");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h00, 0, "post_rst_idle");
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "toi6_req");
        applyStimulus(0, 0, S_TOI,  0, 1, 0, 5'h12, 0, "toi6_ack");
        applyStimulus(1, 0, S_TOI,  0, 0, 0, 5'h00, 0, "rst_in_hold");
        applyStimulus(0, 0, S_TOI,  0, 0, 1, 5'h12, 0, "hold_discarded");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h12, 0, "idle5");
        // NMI held high across reset release needs a fresh edge
        applyStimulus(1, 1, S_NONE, 0, 0, 0, 5'h00, 0, "rst_nmi_high");
        applyStimulus(0, 1, S_NONE, 0, 0, 0, 5'h00, 0, "nmi_high_release");
        applyStimulus(0, 1, S_NONE, 0, 0, 0, 5'h00, 0, "nmi_high_steady");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h00, 0, "nmi_low");
        applyStimulus(0, 1, S_NONE, 0, 0, 1, 5'h1C, 1, "nmi_fresh_edge");
        applyStimulus(0, 1, S_NONE, 0, 1, 0, 5'h1C, 0, "nmi_fresh_ack");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "nmi_fresh_hold");
        applyStimulus(0, 0, S_NONE, 0, 0, 0, 5'h1C, 0, "idle6");
`ifdef HD63701_INTC_CMI_EN
        // CMI ranks above SCI
        applyStimulus(0, 0, S_CMI | S_SCI, 0, 0, 1, 5'h0C, 0, "cmi_req");
        applyStimulus(0, 0, S_CMI | S_SCI, 0, 1, 0, 5'h0C, 0, "cmi_ack");
        applyStimulus(0, 0, S_SCI,         0, 0, 0, 5'h0C, 0, "cmi_hold");
        applyStimulus(0, 0, S_SCI,         0, 0, 1, 5'h10, 0, "sci_after_cmi");
        applyStimulus(0, 0, S_SCI,         0, 1, 0, 5'h10, 0, "sci_ack");
        applyStimulus(0, 0, S_NONE,        0, 0, 0, 5'h10, 0, "sci_hold");
        applyStimulus(0, 0, S_NONE,        0, 0, 0, 5'h10, 0, "idle7");
`endif
        repeat (3) @(posedge mcu_clx2);
        #3;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
